// File: rtl/alu_wide_sequencer.sv
// ---------------------------------------------------------------------------
// alu_wide_sequencer
// Runs one W-bit (W = 4*SLICES) operation on an external 4-bit ALU as SLICES
// consecutive 4-bit passes, least significant slice first. The ALU carry out
// of each pass becomes the carry in of the next. The slices of the result are
// collected into a wide word, and NZCV flags are produced for the whole word.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   start                      request; only looked at in IDLE or DONE
//   op_a, op_b [W-1:0]         operands, captured when start is accepted
//   op_ctrl [2:0], op_cin      ALU control code and slice-0 carry, captured
//   busy                       high while the passes are running
//   done                       one-cycle pulse, res/flags valid
//   res [W-1:0], flag_n/z/c/v  wide result and flags, held until next start
//   alu_a/alu_b [3:0],
//   alu_control [2:0],
//   alu_carryin                operand slice, code and carry sent to the ALU
//   alu_result [3:0],
//   alu_n/z/c/v                combinational ALU response in the same cycle
// ---------------------------------------------------------------------------
module alu_wide_sequencer #(
    parameter int SLICES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*SLICES-1:0]   op_a,
    input  logic [4*SLICES-1:0]   op_b,
    input  logic [2:0]            op_ctrl,
    input  logic                  op_cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*SLICES-1:0]   res,
    output logic                  flag_n,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_v,
    output logic [3:0]            alu_a,
    output logic [3:0]            alu_b,
    output logic [2:0]            alu_control,
    output logic                  alu_carryin,
    input  logic [3:0]            alu_result,
    input  logic                  alu_n,
    input  logic                  alu_z,
    input  logic                  alu_c,
    input  logic                  alu_v
);

    localparam int W  = 4 * SLICES;
    localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            accept_s;
    logic            last_s;
    logic [KW-1:0]   k_r;
    logic            z_acc_r;
    // Operand slices not yet sent to the ALU; the lowest nibble is the next one.
    logic [W-1:0]    a_sh_r;
    logic [W-1:0]    b_sh_r;

    assign last_s = (k_r == KW'(SLICES - 1));

    // Next-state decode and start acceptance.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            res         <= '0;
            flag_n      <= 1'b0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
            flag_v      <= 1'b0;
            alu_a       <= 4'd0;
            alu_b       <= 4'd0;
            alu_control <= 3'd0;
            alu_carryin <= 1'b0;
            k_r         <= '0;
            z_acc_r     <= 1'b0;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s == ST_RUN);
            done    <= (state_s == ST_DONE);
            if (accept_s) begin
                // Slice 0 is presented to the ALU during the first RUN cycle.
                alu_a       <= op_a[3:0];
                alu_b       <= op_b[3:0];
                alu_control <= op_ctrl;
                alu_carryin <= op_cin;
                a_sh_r      <= op_a >> 3'd4;
                b_sh_r      <= op_b >> 3'd4;
                k_r         <= '0;
                z_acc_r     <= 1'b1;
                res         <= '0;
                flag_n      <= 1'b0;
                flag_z      <= 1'b0;
                flag_c      <= 1'b0;
                flag_v      <= 1'b0;
            end else if (state_r == ST_RUN) begin
                for (int i = 0; i < SLICES; i++) begin
                    if (k_r == KW'(i)) begin
                        res[4*i +: 4] <= alu_result;
                    end
                end
                z_acc_r <= z_acc_r & alu_z;
                if (last_s) begin
                    flag_n      <= alu_n;
                    flag_c      <= alu_c;
                    flag_v      <= alu_v;
                    flag_z      <= z_acc_r & alu_z;
                    alu_a       <= 4'd0;
                    alu_b       <= 4'd0;
                    alu_control <= 3'd0;
                    alu_carryin <= 1'b0;
                end else begin
                    // alu_carryin doubles as the carry register between passes.
                    alu_a       <= a_sh_r[3:0];
                    alu_b       <= b_sh_r[3:0];
                    alu_carryin <= alu_c;
                    a_sh_r      <= a_sh_r >> 3'd4;
                    b_sh_r      <= b_sh_r >> 3'd4;
                    k_r         <= k_r + KW'(1);
                end
            end else begin
                alu_a       <= 4'd0;
                alu_b       <= 4'd0;
                alu_control <= 3'd0;
                alu_carryin <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_wide_sequencer
// Drives alu_wide_sequencer (SLICES=2) connected to a behavioural 4-bit ALU.
// A transaction-level reference model predicts every output on every cycle
// from whole-word arithmetic. Directed cases pin the model with literals.
// ---------------------------------------------------------------------------
module tb_alu_wide_sequencer;

    localparam int SLICES = 2;
    localparam int W      = 4 * SLICES;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [2:0]     op_ctrl;
    logic           op_cin;
    logic           busy;
    logic           done;
    logic [W-1:0]   res;
    logic           flag_n, flag_z, flag_c, flag_v;
    logic [3:0]     alu_a, alu_b;
    logic [2:0]     alu_control;
    logic           alu_carryin;
    logic [3:0]     alu_result;
    logic           alu_n, alu_z, alu_c, alu_v;

    int checks   = 0;
    int failures = 0;

    alu_wide_sequencer #(.SLICES(SLICES)) dut (
        .clk(clk), .reset(reset), .start(start),
        .op_a(op_a), .op_b(op_b), .op_ctrl(op_ctrl), .op_cin(op_cin),
        .busy(busy), .done(done), .res(res),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_carryin(alu_carryin),
        .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v)
    );

    always #5 clk = ~clk;

    // 4-bit ALU: 0 add, 1 sub (a + ~b + cin), 2 and, 3 or, 4 xor, 5 nand,
    // 6 not a, 7 pass b. Logic codes pass the carry through, v=0.
    function automatic logic [7:0] alu4(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] ctrl, input logic cin);
        logic [4:0] s;
        logic [3:0] bb, r;
        logic c, v;
        c = cin; v = 1'b0; bb = b; r = 4'd0;
        case (ctrl)
            3'd0, 3'd1: begin
                if (ctrl == 3'd1) bb = ~b;
                s = {1'b0, a} + {1'b0, bb} + {4'd0, cin};
                r = s[3:0];
                c = s[4];
                v = (a[3] == bb[3]) && (r[3] != a[3]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a & b);
            3'd6: r = ~a;
            default: r = b;
        endcase
        return {r[3], (r == 4'd0), c, v, r};
    endfunction

    always_comb {alu_n, alu_z, alu_c, alu_v, alu_result} = alu4(alu_a, alu_b, alu_control, alu_carryin);

    // Whole-word reference: {n, z, c, v, result}.
    function automatic logic [W+3:0] wide_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] ctrl, input logic cin);
        logic [W:0]   s;
        logic [W-1:0] bb, r;
        logic c, v;
        c = cin; v = 1'b0; bb = b; r = '0;
        case (ctrl)
            3'd0, 3'd1: begin
                if (ctrl == 3'd1) bb = ~b;
                s = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a & b);
            3'd6: r = ~a;
            default: r = b;
        endcase
        return {r[W-1], (r == '0), c, v, r};
    endfunction

    // Carry entering slice idx, from the arithmetic of the lower slices.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [2:0] ctrl, input logic cin, input int idx);
        int mask, s;
        logic [W-1:0] bb;
        if (idx == 0 || ctrl > 3'd1) return cin;
        bb   = (ctrl == 3'd1) ? ~b : b;
        mask = (1 << (4 * idx)) - 1;
        s    = (int'(a) & mask) + (int'(bb) & mask) + int'(cin);
        return ((s >> (4 * idx)) & 1) != 0;
    endfunction

    // Transaction model: cnt = RUN cycles still to go after the current edge.
    int             cnt = 0;
    logic           model_valid = 1'b0;
    logic           m_done = 1'b0;
    logic [W+3:0]   pend = '0;
    logic [W+3:0]   m_out = '0;
    logic [W-1:0]   cur_a = '0, cur_b = '0;
    logic [2:0]     cur_ctrl = 3'd0;
    logic           cur_cin = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            cnt <= 0; m_done <= 1'b0; m_out <= '0; model_valid <= 1'b1;
        end else if (model_valid) begin
            if (cnt == 0 && start) begin
                cnt <= SLICES; m_done <= 1'b0; m_out <= '0;
                cur_a <= op_a; cur_b <= op_b; cur_ctrl <= op_ctrl; cur_cin <= op_cin;
                pend <= wide_op(op_a, op_b, op_ctrl, op_cin);
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    m_done <= 1'b1;
                    m_out  <= pend;
                end
            end else begin
                m_done <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            int idx;
            int mask;
            logic [W-1:0] exp_res;
            logic [3:0]   exp_n_z_c_v;
            idx  = SLICES - cnt;
            mask = (1 << (4 * idx)) - 1;
            if (cnt > 0) begin
                exp_res     = pend[W-1:0] & mask[W-1:0];
                exp_n_z_c_v = 4'd0;
            end else begin
                exp_res     = m_out[W-1:0];
                exp_n_z_c_v = m_out[W+3:W];
            end
            check("busy", {31'd0, busy}, {31'd0, (cnt > 0)});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("res", {24'd0, res}, {24'd0, exp_res});
            check("flags", {28'd0, flag_n, flag_z, flag_c, flag_v}, {28'd0, exp_n_z_c_v});
            if (cnt > 0) begin
                check("alu_a", {28'd0, alu_a}, {28'd0, 4'((cur_a >> (4 * idx)) & 8'h0F)});
                check("alu_b", {28'd0, alu_b}, {28'd0, 4'((cur_b >> (4 * idx)) & 8'h0F)});
                check("alu_control", {29'd0, alu_control}, {29'd0, cur_ctrl});
                check("alu_carryin", {31'd0, alu_carryin},
                      {31'd0, carry_into(cur_a, cur_b, cur_ctrl, cur_cin, idx)});
            end else begin
                check("alu_idle", {24'd0, alu_a, alu_b}, 32'd0);
                check("alu_idle_ctl", {28'd0, alu_control, alu_carryin}, 32'd0);
            end
        end
    end

    task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] ctrl, input logic cin);
        start = 1'b1; op_a = a; op_b = b; op_ctrl = ctrl; op_cin = cin;
    endtask

    // Issue one operation from a negedge and return at the negedge showing done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] ctrl, input logic cin);
        int lat;
        set_op(a, b, ctrl, cin);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, SLICES + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, pulses;
        logic [W-1:0] seen;
        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; op_ctrl = 3'd0; op_cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_res_flags", {20'd0, res, flag_n, flag_z, flag_c, flag_v}, 32'd0);
        check("rst_alu", {20'd0, alu_a, alu_b, alu_control, alu_carryin}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: FF + 01
        run_op(8'hFF, 8'h01, 3'd0, 1'b0);
        check("t1_res", {24'd0, res}, 32'h00);
        check("t1_nzcv", {28'd0, flag_n, flag_z, flag_c, flag_v}, 32'b0110);
        @(negedge clk);

        // 2: 7F + 01, carry into slice 1
        set_op(8'h7F, 8'h01, 3'd0, 1'b0);
        @(negedge clk); start = 1'b0;
        check("t2_cin_s0", {31'd0, alu_carryin}, 32'd0);
        @(negedge clk);
        check("t2_cin_s1", {31'd0, alu_carryin}, 32'd1);
        @(negedge clk);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_res", {24'd0, res}, 32'h80);
        check("t2_nzcv", {28'd0, flag_n, flag_z, flag_c, flag_v}, 32'b1001);

        // 3: 0F + 00 + cin
        set_op(8'h0F, 8'h00, 3'd0, 1'b1);
        @(negedge clk); start = 1'b0;
        check("t3_cin_s0", {31'd0, alu_carryin}, 32'd1);
        @(negedge clk); @(negedge clk);
        check("t3_res", {24'd0, res}, 32'h10);
        check("t3_zc", {30'd0, flag_z, flag_c}, 32'd0);
        @(negedge clk);

        // 4: start during busy is ignored
        set_op(8'h12, 8'h34, 3'd0, 1'b0);
        @(negedge clk);
        op_a = 8'h11;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; seen = '0;
        for (int i = 0; i < 6; i++) begin
            if (done) begin pulses++; seen = res; end
            @(negedge clk);
        end
        check("t4_pulses", pulses, 1);
        check("t4_res", {24'd0, seen}, 32'h46);

        // 5: reset during slice 1
        set_op(8'h55, 8'h22, 3'd0, 1'b0);
        @(negedge clk); start = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("t5_busy_done", {30'd0, busy, done}, 32'd0);
        check("t5_res_flags", {20'd0, res, flag_n, flag_z, flag_c, flag_v}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run_op(8'h01, 8'h02, 3'd0, 1'b0);
        check("t5_new_res", {24'd0, res}, 32'h03);
        @(negedge clk);

        // 6: start held through done, sweep all control codes back to back
        set_op(8'($urandom), 8'($urandom), 3'd0, 1'($urandom));
        for (int c = 0; c < 8; c++) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                if (lat == 1) check("t6_busy_after", {30'd0, busy, done}, 32'b10);
            end while (!done && lat < 10);
            check("t6_latency", lat, SLICES + 1);
            if (c < 7) set_op(8'($urandom), 8'($urandom), 3'(c + 1), 1'($urandom));
            else start = 1'b0;
        end
        @(negedge clk);
        check("t6_done_single", {31'd0, done}, 32'd0);

        // Random operations with random idle gaps
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
        end
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
